mult_sched: RTL
===============

# mult_sched

Two-requester scheduler and step sequencer for the shared nibble-serial 8x8 multiplier datapath. The datapath is the 4x4 multiplier, nibble muxes, shifter, accumulate adder and result register. The block arbitrates between two requesters, latches the granted operands, and sequences the four partial-product steps by driving the datapath selects and the accumulator enable. It then reports completion to the owning requester. It sits between the requester logic and the datapath, in place of a single-user controller.

## Interface
Parameters:
- ROUND_ROBIN, 1, 1 = round-robin arbitration; 0 = fixed priority with requester 0 winning.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0, req1  in  1  request from requester 0/1; level, held until the matching ack.
- a0, b0, a1, b1  in  8  operands; sampled only in the cycle of the matching ack.
- ack0, ack1  out  1  one-cycle pulse: request accepted, operands captured.
- done0, done1  out  1  one-cycle pulse: datapath result register holds the owner's product.
- owner  out  1  id of the current or last granted requester.
- busy  out  1  high from ack through done inclusive.
- a_out, b_out  out  8  latched operands to the nibble muxes.
- sela, selb  out  1  1 = high nibble, 0 = low nibble.
- sel_shift  out  2  0 = no shift, 1 = shift by 4, 2 = shift by 8; 3 is never driven.
- data_sel  out  1  0 = adder adds 0 (clear accumulator), 1 = adder adds result register.
- clk_en  out  1  result register load enable.
- state  out  3  encoded FSM state for the seven-segment display.

## Operation
- FSM states: IDLE=0, LOAD=1, STEP0=2, STEP1=3, STEP2=4, STEP3=5, DONE=6.
- IDLE: if req0 or req1 is high, the arbiter picks a winner and the FSM moves to LOAD.
- LOAD: ack of the winner pulses; a_out/b_out capture its operands; owner updates. Next state is STEP0.
- Step selects, as (sela, selb, sel_shift, data_sel); clk_en=1 in every step:
  - STEP0: (0, 0, 0, 0).
  - STEP1: (1, 0, 1, 1).
  - STEP2: (0, 1, 1, 1).
  - STEP3: (1, 1, 2, 1).
  - Steps advance one per cycle; STEP3 goes to DONE.
- DONE: done of the owner pulses; clk_en=0; next state is IDLE.
- Arbitration:
  - Round-robin: on a simultaneous request, the requester not granted last wins.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - A lone request always wins.
- Requests arriving while busy are held off; they are arbitrated on return to IDLE.
- A request deasserted before its ack is lost, with no ack or done. The arbiter samples only in IDLE.
- Outside the steps: clk_en=0, data_sel=0, sela=selb=0, sel_shift=0.

## Timing
- Request seen in IDLE at cycle 0 -> ack at cycle 1 -> clk_en cycles 2–5 -> done at cycle 6.
- The product is valid in the datapath register from cycle 6 until the next STEP0 load.
- Back-to-back: a held request is acked at cycle 8. Throughput is one multiply per 7 cycles.
- Reset values: state=IDLE; all ack, done, busy, clk_en, sel and data_sel outputs 0; a_out=b_out=0; owner=0; last-grant pointer=1.
- Reset mid-operation aborts immediately. No done is issued. The datapath register keeps its own reset behaviour.
- done and ack never assert in the same cycle. At most one of ack0/ack1, and at most one of done0/done1, is high in any cycle.

## Configuration
- MULT_SCHED_ZERO_SKIP_EN defined:
  - In LOAD, if the winner's a or b equals 0x00, the FSM runs STEP0 only, then goes to DONE.
  - STEP0 clears the accumulator and loads a zero product.
  - Latency drops to done at cycle 3.
- Undefined: all operands take the full four-step sequence.

## Structure
- Shared package mult_pkg holds:
  - the state encoding constants (IDLE..DONE, 3 bits);
  - the sel_shift codes SH0/SH4/SH8;
  - the step count of 4.
- One sub-module, rr_arb2: a two-input arbiter with registered last-grant pointer and the ROUND_ROBIN parameter. It is instantiated once.
- The sequencer FSM, operand latches and select decode live in mult_sched.

## Test plan
- Single request: req0 with a0=0x12, b0=0x34 -> ack0 at cycle 1, done0 at cycle 6, datapath result 0x03A8, owner=0.
- Simultaneous requests: req0 and req1 together, a1=0xFF, b1=0xFF -> requester 0 served first. Then ack1 at cycle 8 and done1 at cycle 13, result 0xFE01, owner=1.
- Fairness: both requests held continuously for 6 operations -> grants alternate 0, 1, 0, 1, 0, 1. With ROUND_ROBIN=0, all 6 grants go to 0.
- Select sequence: any operation -> (sela, selb, sel_shift, data_sel) over cycles 2–5 equals (0,0,0,0), (1,0,1,1), (0,1,1,1), (1,1,2,1), with clk_en high exactly those 4 cycles.
- Zero operand, a0=0x00, b0=0x7F: macro defined -> done0 at cycle 3, result 0x0000; macro undefined -> done0 at cycle 6, result 0x0000.
- Reset at cycle 4 of an operation -> state=IDLE and all outputs at reset values in the same cycle. No done. A held request after reset release gets ack 1 cycle later.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared encodings for the nibble-serial multiplier scheduler: FSM states, shifter codes, step count.
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    STEP0 = 3'd2,
    STEP1 = 3'd3,
    STEP2 = 3'd4,
    STEP3 = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [1:0] SH0 = 2'd0;
  localparam logic [1:0] SH4 = 2'd1;
  localparam logic [1:0] SH8 = 2'd2;

  localparam int STEPS = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter, combinational grant; the last-grant pointer only moves when take is high.
// ROUND_ROBIN=0 gives fixed priority to input 0.
module rr_arb2 #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_vld,
  output logic       gnt_id
);

  logic last;

  always_comb begin
    gnt_vld = |req;
    gnt_id  = 1'b0;
    if (req == 2'b10)
      gnt_id = 1'b1;
    else if (req == 2'b11 && ROUND_ROBIN != 0)
      gnt_id = ~last;
  end

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (take && gnt_vld)
      last <= gnt_id;
  end

endmodule

// File: rtl/mult_sched.sv
// Two-requester scheduler and 4-step sequencer for the nibble-serial 8x8 multiplier; ack at +1, done at +6.
// Requests are level-held and only arbitrated in IDLE; MULT_SCHED_ZERO_SKIP_EN enables a one-step path for zero operands.
module mult_sched
  import mult_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic       owner,
  output logic       busy,
  output logic [7:0] a_out,
  output logic [7:0] b_out,
  output logic       sela,
  output logic       selb,
  output logic [1:0] sel_shift,
  output logic       data_sel,
  output logic       clk_en,
  output logic [2:0] state
);

  localparam state_t LAST_STEP = state_t'(STEP0 + 3'(STEPS - 1));

  state_t     state_q, state_d;
  logic       gnt_vld, gnt_id;
  logic       skip_now;
  logic [7:0] a_sel, b_sel;

  rr_arb2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .take    (state_q == IDLE),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign a_sel = owner ? a1 : a0;
  assign b_sel = owner ? b1 : b0;
  assign state = state_q;
  assign busy  = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner   <= 1'b0;
      a_out   <= 8'h00;
      b_out   <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && gnt_vld)
        owner <= gnt_id;
      if (state_q == LOAD) begin
        a_out <= a_sel;
        b_out <= b_sel;
      end
    end
  end

`ifdef MULT_SCHED_ZERO_SKIP_EN
  logic skip_q;

  // A zero operand makes every partial product zero, so STEP0's clearing load is the whole answer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      skip_q <= 1'b0;
    else if (state_q == LOAD)
      skip_q <= (a_sel == 8'h00) || (b_sel == 8'h00);
  end

  assign skip_now = skip_q;
`else
  assign skip_now = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ack0      = 1'b0;
    ack1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    sela      = 1'b0;
    selb      = 1'b0;
    sel_shift = SH0;
    data_sel  = 1'b0;
    clk_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld)
          state_d = LOAD;
      end
      LOAD: begin
        ack0    = ~owner;
        ack1    = owner;
        state_d = STEP0;
      end
      STEP0, STEP1, STEP2, STEP3: begin
        clk_en  = 1'b1;
        state_d = (state_q == LAST_STEP || skip_now) ? DONE : state_t'(state_q + 3'd1);
        case (state_q)
          STEP1: begin
            sela      = 1'b1;
            sel_shift = SH4;
            data_sel  = 1'b1;
          end
          STEP2: begin
            selb      = 1'b1;
            sel_shift = SH4;
            data_sel  = 1'b1;
          end
          STEP3: begin
            sela      = 1'b1;
            selb      = 1'b1;
            sel_shift = SH8;
            data_sel  = 1'b1;
          end
          default: ;
        endcase
      end
      DONE: begin
        done0   = ~owner;
        done1   = owner;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
